// File: rtl/viola_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viola_pkg
// Description : Shared definitions for the reorder buffer and the ALU-side
//               reservation station. Holds the 5-bit opcode encoding, the
//               default ROB tag width and the ALU-op classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package viola_pkg;

  // Default ROB tag width. Tag 0 means "no tag / value valid".
  localparam int TAG_W = 3;

  // ALU-station ops occupy 0..16, so the classifier is a single compare.
  localparam logic [4:0] ADD_OP   = 5'd0;
  localparam logic [4:0] SUB_OP   = 5'd1;
  localparam logic [4:0] AND_OP   = 5'd2;
  localparam logic [4:0] OR_OP    = 5'd3;
  localparam logic [4:0] XOR_OP   = 5'd4;
  localparam logic [4:0] SLL_OP   = 5'd5;
  localparam logic [4:0] SRL_OP   = 5'd6;
  localparam logic [4:0] SRA_OP   = 5'd7;
  localparam logic [4:0] SLT_OP   = 5'd8;
  localparam logic [4:0] SLTU_OP  = 5'd9;
  localparam logic [4:0] BEQ_OP   = 5'd10;
  localparam logic [4:0] BNE_OP   = 5'd11;
  localparam logic [4:0] BLT_OP   = 5'd12;
  localparam logic [4:0] BGE_OP   = 5'd13;
  localparam logic [4:0] BLTU_OP  = 5'd14;
  localparam logic [4:0] BGEU_OP  = 5'd15;
  localparam logic [4:0] JALR_OP  = 5'd16;

  // Ops routed elsewhere (load/store unit, or resolved at dispatch).
  localparam logic [4:0] LB_OP    = 5'd17;
  localparam logic [4:0] LH_OP    = 5'd18;
  localparam logic [4:0] LW_OP    = 5'd19;
  localparam logic [4:0] LBU_OP   = 5'd20;
  localparam logic [4:0] LHU_OP   = 5'd21;
  localparam logic [4:0] SB_OP    = 5'd22;
  localparam logic [4:0] SH_OP    = 5'd23;
  localparam logic [4:0] SW_OP    = 5'd24;
  localparam logic [4:0] LUI_OP   = 5'd25;
  localparam logic [4:0] AUIPC_OP = 5'd26;
  localparam logic [4:0] JAL_OP   = 5'd27;
  localparam logic [4:0] JAL_C_OP = 5'd28;
  localparam logic [4:0] NOP_OP   = 5'b11111;

  // True for ops that this station executes.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op <= JALR_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_alu.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu
// Description : Purely combinational ALU for the reservation station.
//               Computes arithmetic/logic results, 0/1 compare results,
//               branch-taken flags and the JALR target.
// Ports       : i_op     - 5-bit opcode
//               i_v1     - operand 1
//               i_v2     - operand 2 (rs2 or immediate)
//               i_imm    - immediate, used only by JALR
//               o_result - 32-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu
  import viola_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [31:0] i_v1,
  input  logic [31:0] i_v2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_result
);

  logic [4:0]  w_shamt;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;

  assign w_shamt = i_v2[4:0];
  assign w_lt_s  = ($signed(i_v1) < $signed(i_v2));
  assign w_lt_u  = (i_v1 < i_v2);
  assign w_eq    = (i_v1 == i_v2);

  always_comb begin
    o_result = '0;
    case (i_op)
      ADD_OP:  o_result = i_v1 + i_v2;
      SUB_OP:  o_result = i_v1 - i_v2;
      AND_OP:  o_result = i_v1 & i_v2;
      OR_OP:   o_result = i_v1 | i_v2;
      XOR_OP:  o_result = i_v1 ^ i_v2;
      SLL_OP:  o_result = i_v1 << w_shamt;
      SRL_OP:  o_result = i_v1 >> w_shamt;
      SRA_OP:  o_result = $unsigned($signed(i_v1) >>> w_shamt);
      SLT_OP:  o_result = {31'd0, w_lt_s};
      SLTU_OP: o_result = {31'd0, w_lt_u};
      BEQ_OP:  o_result = {31'd0, w_eq};
      BNE_OP:  o_result = {31'd0, ~w_eq};
      BLT_OP:  o_result = {31'd0, w_lt_s};
      BGE_OP:  o_result = {31'd0, ~w_lt_s};
      BLTU_OP: o_result = {31'd0, w_lt_u};
      BGEU_OP: o_result = {31'd0, ~w_lt_u};
      JALR_OP: o_result = (i_v1 + i_imm) & ~32'd1;
      default: o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : ALU-side reservation station. Holds dispatched ALU/branch/
//               JALR ops until both operands are available, snoops the ALU
//               and memory result buses, issues the lowest-index ready slot
//               each cycle and broadcasts the tagged result for one cycle.
// Ports       : clk, rst (sync, active-low), flush (sync, active-high)
//               op_in/value*_in/query*_in/target_in/imm_in - dispatch port
//               mem_num/mem_value - memory result bus (tag 0 = none)
//               rs_full           - no free slot guaranteed next cycle
//               alu_num/alu_value - result broadcast (tag 0 = none)
// Revision    : 1.0 - initial release
// ============================================================================
module reservation_station
  import viola_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = viola_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [4:0]       op_in,
  input  logic [31:0]      value1_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [31:0]      value2_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic [31:0]      imm_in,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [31:0]      mem_value,
  output logic             rs_full,
  output logic [TAG_W-1:0] alu_num,
  output logic [31:0]      alu_value
);

  localparam int c_IDX_W = $clog2(ENTRIES);
  localparam int c_CNT_W = $clog2(ENTRIES + 1);
  localparam logic [c_CNT_W-1:0] c_FULL_TH = c_CNT_W'(ENTRIES - 1);

  // Slot array
  logic [ENTRIES-1:0] r_busy;
  logic [4:0]         r_op  [ENTRIES];
  logic [31:0]        r_v1  [ENTRIES];
  logic [31:0]        r_v2  [ENTRIES];
  logic [31:0]        r_imm [ENTRIES];
  logic [TAG_W-1:0]   r_q1  [ENTRIES];
  logic [TAG_W-1:0]   r_q2  [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];

  // Output registers
  logic [TAG_W-1:0]   r_alu_num;
  logic [31:0]        r_alu_value;
  logic               r_rs_full;

  // Combinational
  logic [ENTRIES-1:0] w_ready;
  logic [ENTRIES-1:0] w_issue_oh;
  logic [ENTRIES-1:0] w_alloc_oh;
  logic [ENTRIES-1:0] w_free;
  logic [ENTRIES-1:0] w_busy_next;
  logic               w_issue_vld;
  logic [c_IDX_W-1:0] w_issue_idx;
  logic               w_accept;
  logic               w_alloc_ok;
  logic [31:0]        w_result;
  logic [c_CNT_W-1:0] w_cnt_next;

  logic [TAG_W-1:0]   w_q1_wk [ENTRIES];
  logic [TAG_W-1:0]   w_q2_wk [ENTRIES];
  logic [31:0]        w_v1_wk [ENTRIES];
  logic [31:0]        w_v2_wk [ENTRIES];
  logic [TAG_W-1:0]   w_q1_new;
  logic [TAG_W-1:0]   w_q2_new;
  logic [31:0]        w_v1_new;
  logic [31:0]        w_v2_new;

  assign alu_num   = r_alu_num;
  assign alu_value = r_alu_value;
  assign rs_full   = r_rs_full;

  // Resolve one operand against both result buses. The memory bus is
  // checked first so it wins when both carry the same tag.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0] q,
    input logic [31:0]      v,
    input logic [TAG_W-1:0] anum,
    input logic [31:0]      aval,
    input logic [TAG_W-1:0] mnum,
    input logic [31:0]      mval
  );
    logic [TAG_W+31:0] res;
    res = {q, v};
    if (q != '0) begin
      if (q == mnum)      res = {{TAG_W{1'b0}}, mval};
      else if (q == anum) res = {{TAG_W{1'b0}}, aval};
    end
    return res;
  endfunction

  // Wakeup of held operands and dispatch-time bypass.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      {w_q1_wk[i], w_v1_wk[i]} = snoop(r_q1[i], r_v1[i], r_alu_num, r_alu_value, mem_num, mem_value);
      {w_q2_wk[i], w_v2_wk[i]} = snoop(r_q2[i], r_v2[i], r_alu_num, r_alu_value, mem_num, mem_value);
    end
    {w_q1_new, w_v1_new} = snoop(query1_in, value1_in, r_alu_num, r_alu_value, mem_num, mem_value);
    {w_q2_new, w_v2_new} = snoop(query2_in, value2_in, r_alu_num, r_alu_value, mem_num, mem_value);
  end

  // Readiness uses registered operand tags only, so a slot woken at an edge
  // cannot issue at that same edge.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
    end
  end

  // Lowest-index ready slot wins; scanning downward lets the last hit be it.
  always_comb begin
    w_issue_vld = 1'b0;
    w_issue_idx = '0;
    w_issue_oh  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_issue_vld = 1'b1;
        w_issue_idx = c_IDX_W'(i);
      end
    end
    if (w_issue_vld) w_issue_oh[w_issue_idx] = 1'b1;
  end

  // A slot being issued this edge counts as free for a same-edge dispatch.
  assign w_free   = ~r_busy | w_issue_oh;
  assign w_accept = is_alu_op(op_in);

  always_comb begin
    w_alloc_ok = 1'b0;
    w_alloc_oh = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_alloc_ok = 1'b1;
        w_alloc_oh = '0;
        w_alloc_oh[i] = w_accept;
      end
    end
  end

  assign w_busy_next = (r_busy & ~w_issue_oh) | w_alloc_oh;

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_cnt_next = w_cnt_next + c_CNT_W'(w_busy_next[i]);
    end
  end

  rs_alu u_alu (
    .i_op     (r_op[w_issue_idx]),
    .i_v1     (r_v1[w_issue_idx]),
    .i_v2     (r_v2[w_issue_idx]),
    .i_imm    (r_imm[w_issue_idx]),
    .o_result (w_result)
  );

  // Control state and outputs. Flush/reset override everything else.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_busy      <= '0;
      r_alu_num   <= '0;
      r_alu_value <= '0;
      r_rs_full   <= 1'b0;
    end else begin
      r_busy      <= w_busy_next;
      r_alu_num   <= w_issue_vld ? r_tag[w_issue_idx] : '0;
      r_alu_value <= w_issue_vld ? w_result : '0;
      r_rs_full   <= (w_cnt_next >= c_FULL_TH);
    end
  end

  // Slot payload. Not reset: contents are ignored whenever busy is clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_alloc_oh[i]) begin
        r_op[i]  <= op_in;
        r_v1[i]  <= w_v1_new;
        r_q1[i]  <= w_q1_new;
        r_v2[i]  <= w_v2_new;
        r_q2[i]  <= w_q2_new;
        r_imm[i] <= imm_in;
        r_tag[i] <= target_in;
      end else begin
        r_v1[i]  <= w_v1_wk[i];
        r_q1[i]  <= w_q1_wk[i];
        r_v2[i]  <= w_v2_wk[i];
        r_q2[i]  <= w_q2_wk[i];
      end
    end
  end

  // Upstream must honour rs_full; a dispatch with no free slot is dropped.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      assert (!(w_accept && !w_alloc_ok))
        else $error("reservation_station: dispatch with no free slot dropped");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservation_station
// Description : Self-checking bench for reservation_station: directed
//               sequences, an ALU vector table and a randomized run against
//               a behavioural slot model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;
  import viola_pkg::*;

  localparam int ENTRIES = 4;
  localparam int TW      = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [4:0]    op_in;
  logic [31:0]   value1_in;
  logic [TW-1:0] query1_in;
  logic [31:0]   value2_in;
  logic [TW-1:0] query2_in;
  logic [TW-1:0] target_in;
  logic [31:0]   imm_in;
  logic [TW-1:0] mem_num;
  logic [31:0]   mem_value;
  logic          rs_full;
  logic [TW-1:0] alu_num;
  logic [31:0]   alu_value;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reservation_station #(.ENTRIES(ENTRIES), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .op_in     (op_in),
    .value1_in (value1_in),
    .query1_in (query1_in),
    .value2_in (value2_in),
    .query2_in (query2_in),
    .target_in (target_in),
    .imm_in    (imm_in),
    .mem_num   (mem_num),
    .mem_value (mem_value),
    .rs_full   (rs_full),
    .alu_num   (alu_num),
    .alu_value (alu_value)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush     = 1'b0;
    op_in     = NOP_OP;
    value1_in = '0;
    query1_in = '0;
    value2_in = '0;
    query2_in = '0;
    target_in = '0;
    imm_in    = '0;
    mem_num   = '0;
    mem_value = '0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] v1, input logic [TW-1:0] q1,
                      input logic [31:0] v2, input logic [TW-1:0] q2,
                      input logic [31:0] imm, input logic [TW-1:0] tgt);
    op_in = op; value1_in = v1; query1_in = q1; value2_in = v2; query2_in = q2;
    imm_in = imm; target_in = tgt;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference ALU (independent formulation) -------------
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic [4:0] s;
    logic lts, ltu;
    s   = b[4:0];
    ltu = (a < b);
    lts = (a[31] != b[31]) ? a[31] : ltu;
    case (op)
      ADD_OP:  return a + b;
      SUB_OP:  return a + ~b + 32'd1;
      AND_OP:  return a & b;
      OR_OP:   return a | b;
      XOR_OP:  return a ^ b;
      SLL_OP:  return a << s;
      SRL_OP:  return a >> s;
      SRA_OP:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      SLT_OP:  return {31'd0, lts};
      SLTU_OP: return {31'd0, ltu};
      BEQ_OP:  return {31'd0, a == b};
      BNE_OP:  return {31'd0, a != b};
      BLT_OP:  return {31'd0, lts};
      BGE_OP:  return {31'd0, !lts};
      BLTU_OP: return {31'd0, ltu};
      BGEU_OP: return {31'd0, !ltu};
      JALR_OP: return {a[31:1] + imm[31:1] + {30'd0, a[0] & imm[0]}, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- behavioural station model ---------------------------
  typedef struct {
    logic          busy;
    logic [4:0]    op;
    logic [31:0]   v1, v2, imm;
    logic [TW-1:0] q1, q2, tag;
  } slot_t;

  slot_t         m [ENTRIES];
  logic [TW-1:0] m_num;
  logic [31:0]   m_val;
  logic          m_full;

  function automatic logic [TW+31:0] res(input logic [TW-1:0] q, input logic [31:0] v);
    if (q != 0 && q == mem_num) return {{TW{1'b0}}, mem_value};
    if (q != 0 && q == m_num)   return {{TW{1'b0}}, m_val};
    return {q, v};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m[i].busy = 1'b0;
    m_num = '0; m_val = '0; m_full = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    int            iss;
    int            cnt;
    logic [TW-1:0] nn;
    logic [31:0]   nv;
    iss = -1; nn = '0; nv = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (iss < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) iss = i;
    if (iss >= 0) begin
      nn = m[iss].tag;
      nv = ref_alu(m[iss].op, m[iss].v1, m[iss].v2, m[iss].imm);
      m[iss].busy = 1'b0;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (m[i].busy) begin
        {m[i].q1, m[i].v1} = res(m[i].q1, m[i].v1);
        {m[i].q2, m[i].v2} = res(m[i].q2, m[i].v2);
      end
    end
    if (is_alu_op(op_in)) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!m[i].busy) begin
          m[i].busy = 1'b1;
          m[i].op   = op_in;
          m[i].imm  = imm_in;
          m[i].tag  = target_in;
          {m[i].q1, m[i].v1} = res(query1_in, value1_in);
          {m[i].q2, m[i].v2} = res(query2_in, value2_in);
          break;
        end
      end
    end
    cnt = 0;
    for (int i = 0; i < ENTRIES; i++) if (m[i].busy) cnt++;
    m_full = (cnt >= ENTRIES - 1);
    m_num  = nn;
    m_val  = nv;
    if (flush) model_clear();
  endtask

  // ---------------- ALU vector table -----------------------------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] v1, v2, imm, exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{BLT_OP,  32'hFFFF_FFFF, 32'd1,          32'd0, 32'd1};
    vt[1]  = '{BLTU_OP, 32'hFFFF_FFFF, 32'd1,          32'd0, 32'd0};
    vt[2]  = '{SRA_OP,  32'h8000_0000, 32'd4,          32'd0, 32'hF800_0000};
    vt[3]  = '{JALR_OP, 32'h0000_1001, 32'd9,          32'd4, 32'h0000_1004};
    vt[4]  = '{ADD_OP,  32'hFFFF_FFFF, 32'd2,          32'd0, 32'd1};
    vt[5]  = '{SUB_OP,  32'd3,         32'd5,          32'd0, 32'hFFFF_FFFE};
    vt[6]  = '{AND_OP,  32'h0000_F0F0, 32'h0000_FF00,  32'd0, 32'h0000_F000};
    vt[7]  = '{OR_OP,   32'h0000_F0F0, 32'h0000_0F00,  32'd0, 32'h0000_FFF0};
    vt[8]  = '{XOR_OP,  32'h0000_00FF, 32'h0000_000F,  32'd0, 32'h0000_00F0};
    vt[9]  = '{SLL_OP,  32'd1,         32'h0000_0021,  32'd0, 32'd2};
    vt[10] = '{SRL_OP,  32'h8000_0000, 32'd4,          32'd0, 32'h0800_0000};
    vt[11] = '{SLT_OP,  32'hFFFF_FFFF, 32'd1,          32'd0, 32'd1};
    vt[12] = '{SLTU_OP, 32'hFFFF_FFFF, 32'd1,          32'd0, 32'd0};
    vt[13] = '{BEQ_OP,  32'd7,         32'd7,          32'd0, 32'd1};
    vt[14] = '{BNE_OP,  32'd7,         32'd7,          32'd0, 32'd0};
    vt[15] = '{BGE_OP,  32'hFFFF_FFFF, 32'd1,          32'd0, 32'd0};
    vt[16] = '{BGEU_OP, 32'hFFFF_FFFF, 32'd1,          32'd0, 32'd1};
  end

  // ---------------- main sequence --------------------------------------
  initial begin
    idle();
    rst = 1'b0;
    #1;

    // Reset
    step(); step();
    check("reset alu_num",   32'(alu_num), 32'd0);
    check("reset alu_value", alu_value,    32'd0);
    check("reset rs_full",   32'(rs_full), 32'd0);
    rst = 1'b1;
    disp(ADD_OP, 32'd5, 0, 32'd7, 0, 32'd0, 3'd3);
    step(); idle();
    check("add no early result", 32'(alu_num), 32'd0);
    step();
    check("add alu_num",   32'(alu_num), 32'd3);
    check("add alu_value", alu_value,    32'd12);
    step();
    check("result pulse ends", 32'(alu_num), 32'd0);

    // Dependency on memory result
    disp(SUB_OP, 32'd0, 3'd2, 32'd1, 0, 32'd0, 3'd4);
    step(); idle();
    step();
    mem_num = 3'd2; mem_value = 32'd10;
    step(); idle();
    check("dep not issued at capture edge", 32'(alu_num), 32'd0);
    step();
    check("dep alu_num",   32'(alu_num), 32'd4);
    check("dep alu_value", alu_value,    32'd9);

    // Dispatch bypass from the ALU bus
    disp(ADD_OP, 32'h10, 0, 32'd0, 0, 32'd0, 3'd5);
    step(); idle();
    step();
    check("bypass producer tag", 32'(alu_num), 32'd5);
    disp(ADD_OP, 32'd0, 3'd5, 32'd1, 0, 32'd0, 3'd6);
    step(); idle();
    step();
    check("bypass alu_num",   32'(alu_num), 32'd6);
    check("bypass alu_value", alu_value,    32'h11);

    // ALU vector table, one dispatch per cycle, results one edge later
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) disp(vt[i].op, vt[i].v1, 0, vt[i].v2, 0, vt[i].imm, TW'((i % 7) + 1));
      else idle();
      step();
      if (i > 0) begin
        check($sformatf("vec%0d tag", i - 1), 32'(alu_num), 32'((i - 1) % 7 + 1));
        check($sformatf("vec%0d op%0d value", i - 1, vt[i - 1].op), alu_value, vt[i - 1].exp);
      end
    end
    idle();

    // Full and flush
    for (int i = 1; i <= 3; i++) begin
      disp(ADD_OP, 32'd0, 3'd7, 32'd1, 0, 32'd0, TW'(i));
      step();
      check($sformatf("full after %0d blocked", i), 32'(rs_full), (i == 3) ? 32'd1 : 32'd0);
    end
    disp(ADD_OP, 32'd1, 0, 32'd1, 0, 32'd0, 3'd5);
    flush = 1'b1; mem_num = 3'd7; mem_value = 32'd1;
    step(); idle();
    check("flush rs_full", 32'(rs_full), 32'd0);
    check("flush alu_num", 32'(alu_num), 32'd0);
    mem_num = 3'd7; mem_value = 32'd1;
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flushed op issued %0d", i), 32'(alu_num), 32'd0);
    end

    // Non-ALU ops are not allocated
    disp(ADD_OP, 32'd0, 3'd7, 32'd0, 0, 32'd0, 3'd1); step();
    disp(ADD_OP, 32'd0, 3'd7, 32'd0, 0, 32'd0, 3'd2); step();
    check("two blocked not full", 32'(rs_full), 32'd0);
    disp(LW_OP,    32'd1, 0, 32'd1, 0, 32'd0, 3'd3); step();
    check("LW not allocated", 32'(rs_full), 32'd0);
    disp(LUI_OP,   32'd1, 0, 32'd1, 0, 32'd0, 3'd3); step();
    check("LUI not allocated", 32'(rs_full), 32'd0);
    disp(JAL_C_OP, 32'd1, 0, 32'd1, 0, 32'd0, 3'd3); step();
    check("JAL_C not allocated", 32'(rs_full), 32'd0);
    check("non-ALU no result", 32'(alu_num), 32'd0);
    disp(ADD_OP, 32'd0, 3'd7, 32'd0, 0, 32'd0, 3'd3); step();
    check("third blocked full", 32'(rs_full), 32'd1);
    idle();
    flush = 1'b1; step(); idle();

    // Randomized run against the model
    model_clear();
    for (int c = 0; c < 600; c++) begin
      int r;
      flush = ($urandom_range(0, 59) == 0);
      op_in = NOP_OP;
      if (!m_full && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 20);
        op_in = (r < 17) ? 5'(r) : (r == 17) ? LW_OP : (r == 18) ? LUI_OP :
                (r == 19) ? SW_OP : NOP_OP;
      end
      value1_in = $urandom;
      value2_in = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      imm_in    = $urandom;
      query1_in = ($urandom_range(0, 1) == 1) ? TW'($urandom_range(1, 7)) : '0;
      query2_in = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 7)) : '0;
      target_in = TW'($urandom_range(1, 7));
      mem_num   = ($urandom_range(0, 1) == 0) ? TW'($urandom_range(1, 7)) : '0;
      mem_value = $urandom;
      @(posedge clk);
      model_edge();
      #1;
      check("rand alu_num",   32'(alu_num), 32'(m_num));
      check("rand alu_value", alu_value,    m_val);
      check("rand rs_full",   32'(rs_full), 32'(m_full));
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
